alu_secuencial: RTL and testbench



---
 rtl/alu_secuencial.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_secuencial.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_secuencial.sv
// Registered ALU with in/out valid-ready handshakes; 1-cycle logic/arith ops, iterative shifts (n cycles) and MUL (ANCHO cycles).
// Entrada_Lista only in IDLE and results held in DONE until Salida_Lista; macro ALU_SECUENCIAL_MUL_EN enables the multiplier.
module alu_secuencial #(
  parameter int ANCHO      = 8,
  parameter int ANCHO_DESP = $clog2(ANCHO) + 1
) (
  input  logic             Reloj,
  input  logic             Reset_n,
  input  logic             Entrada_Valida,
  output logic             Entrada_Lista,
  input  logic [ANCHO-1:0] R0,
  input  logic [ANCHO-1:0] RX,
  input  logic [3:0]       Operacion,
  output logic             Salida_Valida,
  input  logic             Salida_Lista,
  output logic [ANCHO-1:0] Resultado,
  output logic [3:0]       Banderas,
  output logic             Ocupado
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} estado_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
`ifdef ALU_SECUENCIAL_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;
`endif
  localparam logic [ANCHO_DESP-1:0] ANCHO_N = ANCHO_DESP'(ANCHO);
  localparam logic [ANCHO_DESP-1:0] CNT_UNO = ANCHO_DESP'(1);

  estado_t               estado_q;
  logic [3:0]            op_q;
  logic [ANCHO-1:0]      desp_q;
  logic                  c_q;
  logic                  carry_q;
  logic [ANCHO_DESP-1:0] cnt_q;
  logic [ANCHO-1:0]      resultado_q;
  logic [3:0]            banderas_q;
  logic                  entrada_lista_q;
  logic                  salida_valida_q;
  logic                  ocupado_q;

  logic [ANCHO:0]        arit;
  logic [ANCHO-1:0]      res_d;
  logic                  c_d, v_d, legal_d, iter_d;
  logic [ANCHO_DESP-1:0] amt, n_d, cnt_d;
  logic [ANCHO-1:0]      desp_nx, fin_res;
  logic                  c_nx, fin_c;

  function automatic logic [3:0] banderas_de(input logic [ANCHO-1:0] r, input logic c, input logic v);
    return {v, r[ANCHO-1], c, (r == '0)};
  endfunction

`ifdef ALU_SECUENCIAL_MUL_EN
  logic [ANCHO-1:0]   mcand_q;
  logic [2*ANCHO-1:0] prod_q, prod_nx;
  logic [ANCHO:0]     suma;

  // Shift-add step: conditionally add the multiplicand into the high half, then shift the whole product right.
  always_comb begin
    suma    = {1'b0, prod_q[2*ANCHO-1:ANCHO]} + (prod_q[0] ? {1'b0, mcand_q} : {(ANCHO+1){1'b0}});
    prod_nx = {suma, prod_q[ANCHO-1:1]};
  end
`endif

  always_comb begin
    amt     = RX[ANCHO_DESP-1:0];
    n_d     = (amt > ANCHO_N) ? ANCHO_N : amt;
    cnt_d   = n_d;
    arit    = '0;
    res_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    legal_d = 1'b1;
    iter_d  = 1'b0;
    case (Operacion)
      OP_ADD, OP_ADC: begin
        arit  = {1'b0, R0} + {1'b0, RX} + {{ANCHO{1'b0}}, (Operacion == OP_ADC) & carry_q};
        res_d = arit[ANCHO-1:0];
        c_d   = arit[ANCHO];
        v_d   = (R0[ANCHO-1] == RX[ANCHO-1]) && (res_d[ANCHO-1] != R0[ANCHO-1]);
      end
      OP_SUB, OP_SBB: begin
        arit  = {1'b0, R0} - {1'b0, RX} - {{ANCHO{1'b0}}, (Operacion == OP_SBB) & carry_q};
        res_d = arit[ANCHO-1:0];
        c_d   = arit[ANCHO];
        v_d   = (R0[ANCHO-1] != RX[ANCHO-1]) && (res_d[ANCHO-1] != R0[ANCHO-1]);
      end
      OP_SHL, OP_SHR, OP_ASR: begin
        res_d  = R0;
        iter_d = (n_d != '0);
      end
      OP_NOT: res_d = ~RX;
      OP_AND: res_d = R0 & RX;
      OP_OR:  res_d = R0 | RX;
      OP_XOR: res_d = R0 ^ RX;
`ifdef ALU_SECUENCIAL_MUL_EN
      OP_MUL: begin
        iter_d = 1'b1;
        cnt_d  = ANCHO_N;
      end
`endif
      default: legal_d = 1'b0;
    endcase
  end

  always_comb begin
    desp_nx = desp_q;
    c_nx    = c_q;
    case (op_q)
      OP_SHL: begin
        c_nx    = desp_q[ANCHO-1];
        desp_nx = {desp_q[ANCHO-2:0], 1'b0};
      end
      OP_SHR: begin
        c_nx    = desp_q[0];
        desp_nx = {1'b0, desp_q[ANCHO-1:1]};
      end
      OP_ASR: begin
        c_nx    = desp_q[0];
        desp_nx = {desp_q[ANCHO-1], desp_q[ANCHO-1:1]};
      end
      default: ;
    endcase
    fin_res = desp_nx;
    fin_c   = c_nx;
`ifdef ALU_SECUENCIAL_MUL_EN
    if (op_q == OP_MUL) begin
      fin_res = prod_nx[ANCHO-1:0];
      fin_c   = |prod_nx[2*ANCHO-1:ANCHO];
    end
`endif
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q        <= IDLE;
      op_q            <= '0;
      desp_q          <= '0;
      c_q             <= 1'b0;
      carry_q         <= 1'b0;
      cnt_q           <= '0;
      resultado_q     <= '0;
      banderas_q      <= '0;
      entrada_lista_q <= 1'b1;
      salida_valida_q <= 1'b0;
      ocupado_q       <= 1'b0;
`ifdef ALU_SECUENCIAL_MUL_EN
      mcand_q         <= '0;
      prod_q          <= '0;
`endif
    end else begin
      case (estado_q)
        IDLE: begin
          if (Entrada_Valida) begin
            op_q            <= Operacion;
            desp_q          <= R0;
            c_q             <= 1'b0;
            cnt_q           <= cnt_d;
            entrada_lista_q <= 1'b0;
`ifdef ALU_SECUENCIAL_MUL_EN
            mcand_q         <= R0;
            prod_q          <= {{ANCHO{1'b0}}, RX};
`endif
            if (iter_d) begin
              estado_q  <= BUSY;
              ocupado_q <= 1'b1;
            end else begin
              estado_q        <= DONE;
              salida_valida_q <= 1'b1;
              resultado_q     <= res_d;
              banderas_q      <= banderas_de(res_d, c_d, v_d);
              if (legal_d) carry_q <= c_d;
            end
          end
        end
        BUSY: begin
          desp_q <= desp_nx;
          c_q    <= c_nx;
          cnt_q  <= cnt_q - CNT_UNO;
`ifdef ALU_SECUENCIAL_MUL_EN
          prod_q <= prod_nx;
`endif
          if (cnt_q == CNT_UNO) begin
            estado_q        <= DONE;
            ocupado_q       <= 1'b0;
            salida_valida_q <= 1'b1;
            resultado_q     <= fin_res;
            banderas_q      <= banderas_de(fin_res, fin_c, 1'b0);
            carry_q         <= fin_c;
          end
        end
        DONE: begin
          if (Salida_Lista) begin
            estado_q        <= IDLE;
            salida_valida_q <= 1'b0;
            entrada_lista_q <= 1'b1;
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign Entrada_Lista = entrada_lista_q;
  assign Salida_Valida = salida_valida_q;
  assign Resultado     = resultado_q;
  assign Banderas      = banderas_q;
  assign Ocupado       = ocupado_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed-vector bench for alu_secuencial (ANCHO=8); expectations follow ALU_SECUENCIAL_MUL_EN when defined.
`timescale 1ns/1ps
module tb_alu_secuencial;

  logic       Reloj          = 1'b0;
  logic       Reset_n        = 1'b0;
  logic       Entrada_Valida = 1'b0;
  logic       Salida_Lista   = 1'b0;
  logic [7:0] R0             = '0;
  logic [7:0] RX             = '0;
  logic [3:0] Operacion      = '0;
  logic       Entrada_Lista, Salida_Valida, Ocupado;
  logic [7:0] Resultado;
  logic [3:0] Banderas;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int busy     = 0;

  always #5 Reloj = ~Reloj;

  alu_secuencial #(.ANCHO(8)) dut (
    .Reloj          (Reloj),
    .Reset_n        (Reset_n),
    .Entrada_Valida (Entrada_Valida),
    .Entrada_Lista  (Entrada_Lista),
    .R0             (R0),
    .RX             (RX),
    .Operacion      (Operacion),
    .Salida_Valida  (Salida_Valida),
    .Salida_Lista   (Salida_Lista),
    .Resultado      (Resultado),
    .Banderas       (Banderas),
    .Ocupado        (Ocupado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called one step after a clock edge with the block in IDLE; returns with the block in DONE.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int edges;
    Operacion      = op;
    R0             = a;
    RX             = b;
    Entrada_Valida = 1'b1;
    @(posedge Reloj); #1;
    Entrada_Valida = 1'b0;
    edges = 0;
    busy  = 0;
    while (!Salida_Valida && edges < 40) begin
      if (Ocupado) busy++;
      @(posedge Reloj); #1;
      edges++;
    end
    // A direct IDLE->DONE transition is the one-cycle case.
    lat = (edges == 0) ? 1 : edges;
    if (!Salida_Valida) lat = -1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] r, input logic [3:0] f, input int l);
    check({tag, ".res"}, 32'(Resultado), 32'(r));
    check({tag, ".flags"}, 32'(Banderas), 32'(f));
    check({tag, ".lat"}, 32'(lat), 32'(l));
    check({tag, ".in_rdy"}, 32'(Entrada_Lista), 32'd0);
  endtask

  task automatic release_out();
    Salida_Lista = 1'b1;
    @(posedge Reloj); #1;
    Salida_Lista = 1'b0;
  endtask

  task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input string tag, input logic [7:0] r, input logic [3:0] f, input int l);
    do_op(op, a, b);
    expect_out(tag, r, f, l);
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst.res", 32'(Resultado), 32'd0);
    check("rst.flags", 32'(Banderas), 32'd0);
    check("rst.out_vld", 32'(Salida_Valida), 32'd0);
    check("rst.in_rdy", 32'(Entrada_Lista), 32'd1);
    check("rst.busy", 32'(Ocupado), 32'd0);
    @(posedge Reloj); #1;
    Reset_n = 1'b1;
    @(posedge Reloj); #1;

    // Abort a long ASR by reset partway through.
    Operacion = 4'd10; R0 = 8'h80; RX = 8'h08; Entrada_Valida = 1'b1;
    @(posedge Reloj); #1;
    Entrada_Valida = 1'b0;
    repeat (3) @(posedge Reloj);
    #1;
    check("abort.busy_before", 32'(Ocupado), 32'd1);
    Reset_n = 1'b0;
    #20;
    Reset_n = 1'b1;
    @(posedge Reloj); #1;
    check("abort.out_vld", 32'(Salida_Valida), 32'd0);
    check("abort.res", 32'(Resultado), 32'd0);
    check("abort.flags", 32'(Banderas), 32'd0);
    check("abort.in_rdy", 32'(Entrada_Lista), 32'd1);

    run(4'd0, 8'hFF, 8'h01, "add",  8'h00, 4'b0011, 1);
    run(4'd8, 8'h00, 8'h00, "adc",  8'h01, 4'b0000, 1);
    run(4'd1, 8'h7F, 8'hFF, "sub",  8'h80, 4'b1110, 1);
    run(4'd9, 8'h10, 8'h0F, "sbb",  8'h00, 4'b0001, 1);

    do_op(4'd2, 8'h81, 8'h03);
    expect_out("shl3", 8'h08, 4'b0000, 3);
    check("shl3.busy_cycles", 32'(busy), 32'd3);
    release_out();

    run(4'd10, 8'h80, 8'h09, "asr9", 8'hFF, 4'b0110, 8);
    run(4'd3,  8'h01, 8'h01, "shr1", 8'h00, 4'b0011, 1);
    run(4'd2,  8'hA5, 8'h10, "shl0", 8'hA5, 4'b0100, 1);

    // Carry set to 1 before MUL shows whether op 11 updates or preserves it.
    run(4'd0, 8'hFF, 8'h01, "add2", 8'h00, 4'b0011, 1);
`ifdef ALU_SECUENCIAL_MUL_EN
    run(4'd11, 8'h03, 8'h05, "mul_a", 8'h0F, 4'b0000, 8);
    run(4'd8,  8'h00, 8'h00, "adc_m", 8'h00, 4'b0001, 1);
    run(4'd11, 8'h10, 8'h11, "mul_b", 8'h10, 4'b0010, 8);
`else
    run(4'd11, 8'h03, 8'h05, "mul_a", 8'h00, 4'b0001, 1);
    run(4'd8,  8'h00, 8'h00, "adc_m", 8'h01, 4'b0000, 1);
    run(4'd11, 8'h10, 8'h11, "mul_b", 8'h00, 4'b0001, 1);
`endif

    run(4'd4, 8'h00, 8'h0F, "not", 8'hF0, 4'b0100, 1);
    run(4'd5, 8'hF0, 8'h3C, "and", 8'h30, 4'b0000, 1);
    run(4'd6, 8'hF0, 8'h3C, "or",  8'hFC, 4'b0100, 1);
    run(4'd7, 8'hF0, 8'h3C, "xor", 8'hCC, 4'b0100, 1);

    run(4'd0,  8'hFF, 8'h01, "add3",   8'h00, 4'b0011, 1);
    run(4'd13, 8'h55, 8'hAA, "ill13",  8'h00, 4'b0001, 1);
    run(4'd8,  8'h00, 8'h00, "adc_il", 8'h01, 4'b0000, 1);

    // Backpressure: hold the result while a new request waits upstream.
    do_op(4'd7, 8'h0F, 8'h3C);
    expect_out("bp", 8'h33, 4'b0000, 1);
    Operacion = 4'd0; R0 = 8'h01; RX = 8'h02; Entrada_Valida = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Reloj); #1;
      check("bp.hold_res", 32'(Resultado), 32'h33);
      check("bp.hold_flags", 32'(Banderas), 32'd0);
      check("bp.hold_vld", 32'(Salida_Valida), 32'd1);
      check("bp.hold_in_rdy", 32'(Entrada_Lista), 32'd0);
    end
    Salida_Lista = 1'b1;
    @(posedge Reloj); #1;
    Salida_Lista = 1'b0;
    check("bp.rel_vld", 32'(Salida_Valida), 32'd0);
    check("bp.rel_in_rdy", 32'(Entrada_Lista), 32'd1);
    @(posedge Reloj); #1;
    Entrada_Valida = 1'b0;
    check("bp.next_vld", 32'(Salida_Valida), 32'd1);
    check("bp.next_res", 32'(Resultado), 32'h03);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
